// File: rtl/nibbler_core_p_if.sv
// nibbler_core_p_if: program memory fetch handshake between core (master) and memory (slave)
interface nibbler_core_p_if #(parameter int ADDR_W = 12);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ack;
  logic [ADDR_W+3:0] rdata;
  modport master (output req, addr, input ack, rdata);
  modport slave (input req, addr, output ack, rdata);
endinterface

// File: rtl/nibbler_core_p.sv
// nibbler_core_p: accumulator core with req/ack instruction fetch, data RAM and banked I/O ports
module nibbler_core_p #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 12,
  parameter int RAM_AW = 8,
  parameter int N_IN   = 3,
  parameter int N_OUT  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  nibbler_core_p_if.master        imem,
  input  logic [N_IN*DATA_W-1:0]  in_data,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic [N_OUT-1:0]        out_we,
  output logic [DATA_W-1:0]       acc,
  output logic                    flag_c,
  output logic                    flag_z,
  output logic [ADDR_W-1:0]       pc
);
  typedef enum logic [1:0] {FETCH, EXEC, MEM} state_t;
  state_t state;
  logic req;
  logic [ADDR_W+3:0] ir;
  logic [3:0] op, port;
  logic [ADDR_W-1:0] f;
  logic [RAM_AW-1:0] ra;
  logic [DATA_W-1:0] imm, rd, lg;
  logic [DATA_W:0] sum, dif;
  logic [DATA_W-1:0] in_arr [16];
  logic [DATA_W-1:0] ram [2**RAM_AW];
  assign op = ir[ADDR_W +: 4];
  assign f = ir[ADDR_W-1:0];
  assign imm = f[DATA_W-1:0];
  assign port = f[3:0];
  assign ra = f[RAM_AW-1:0];
  // ADDM reuses the adder with the RAM word once the read has landed in MEM
  assign sum = {1'b0, acc} + {1'b0, state == MEM ? rd : imm};
  assign dif = {1'b0, acc} - {1'b0, imm};
  assign lg = op == 4'h4 ? acc & imm : op == 4'h5 ? acc | imm : acc ^ imm;
  assign imem.req = req;
  assign imem.addr = pc;
  for (genvar k = 0; k < 16; k++) begin : g_in
    if (k < N_IN) begin : g_v
      assign in_arr[k] = in_data[k*DATA_W +: DATA_W];
    end else begin : g_z
      assign in_arr[k] = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset && state == EXEC && op == 4'h9) ram[ra] <= acc;
    rd <= ram[ra];
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FETCH;
      req <= 1'b0;
      ir <= '0;
      pc <= '0;
      acc <= '0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
      out_data <= '0;
      out_we <= '0;
    end else begin
      out_we <= '0;
      case (state)
        FETCH: begin
          // once raised, req holds until the memory accepts it
          if (req && imem.ack) begin
            ir <= imem.rdata;
            pc <= pc + 1'b1;
            req <= 1'b0;
            state <= EXEC;
          end else req <= req || run;
        end
        EXEC: begin
          state <= (op == 4'h8 || op == 4'hA) ? MEM : FETCH;
          req <= run && op != 4'h8 && op != 4'hA;
          case (op)
            4'h1: acc <= imm;
            4'h2: begin
              acc <= sum[DATA_W-1:0];
              flag_c <= sum[DATA_W];
              flag_z <= sum[DATA_W-1:0] == '0;
            end
            4'h3: begin
              acc <= dif[DATA_W-1:0];
              flag_c <= dif[DATA_W];
              flag_z <= dif[DATA_W-1:0] == '0;
            end
            4'h4, 4'h5, 4'h6: begin
              acc <= lg;
              flag_c <= 1'b0;
              flag_z <= lg == '0;
            end
            4'h7: begin
              flag_c <= dif[DATA_W];
              flag_z <= dif[DATA_W-1:0] == '0;
            end
            4'hB: acc <= in_arr[port];
            4'hC: for (int k = 0; k < N_OUT; k++) if (port == 4'(k)) begin
              out_data[k*DATA_W +: DATA_W] <= acc;
              out_we[k] <= 1'b1;
            end
            4'hD: pc <= f;
            4'hE: if (flag_c) pc <= f;
            4'hF: if (!flag_z) pc <= f;
            default: ;
          endcase
        end
        default: begin
          state <= FETCH;
          req <= run;
          if (op == 4'h8) acc <= rd;
          else begin
            acc <= sum[DATA_W-1:0];
            flag_c <= sum[DATA_W];
            flag_z <= sum[DATA_W-1:0] == '0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nibbler_core_p.sv
// tb_nibbler_core_p: randomized fetch timing and programs checked against an instruction-level model
module tb_nibbler_core_p;
  logic clk = 0, rst_n = 0, run = 0;
  logic [11:0] in_data, out_data, pc;
  logic [2:0] out_we;
  logic [3:0] acc;
  logic flag_c, flag_z;
  nibbler_core_p_if #(.ADDR_W(12)) bus();
  nibbler_core_p dut (
    .clk(clk), .reset(rst_n), .run(run), .imem(bus), .in_data(in_data),
    .out_data(out_data), .out_we(out_we), .acc(acc), .flag_c(flag_c), .flag_z(flag_z), .pc(pc)
  );
  logic [15:0] prog [4096];
  assign bus.rdata = prog[bus.addr];
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0, nfetch = 0, wmax = 0, wcnt = 0, we_t = -1;
  bit active = 0;
  logic [2:0] we_v = '0;
  logic prev_req = 0, prev_ack = 0;
  logic [11:0] prev_addr = '0;
  logic [11:0] m_pc;
  logic [3:0] m_acc;
  logic m_c, m_z;
  logic [3:0] m_out [3];
  logic [3:0] m_ram [256];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic int new_wait();
    return wmax < 0 ? int'($urandom_range(0, 3)) : wmax;
  endfunction

  // One instruction executed atomically from the ISA rules
  task automatic exec_ins(input logic [15:0] ins);
    int op = int'(ins[15:12]);
    logic [11:0] f = ins[11:0];
    int a = int'(m_acc);
    int b = int'(f[3:0]);
    int p = int'(f[3:0]);
    int r;
    m_pc = m_pc + 12'd1;
    case (op)
      1: m_acc = f[3:0];
      2, 10: begin
        if (op == 10) b = int'(m_ram[f[7:0]]);
        r = a + b;
        m_acc = 4'(r);
        m_c = r > 15;
        m_z = (r % 16) == 0;
      end
      3, 7: begin
        r = (a - b + 16) % 16;
        m_c = a < b;
        m_z = r == 0;
        if (op == 3) m_acc = 4'(r);
      end
      4, 5, 6: begin
        r = op == 4 ? (a & b) : op == 5 ? (a | b) : (a ^ b);
        m_acc = 4'(r);
        m_c = 0;
        m_z = r == 0;
      end
      8: m_acc = m_ram[f[7:0]];
      9: m_ram[f[7:0]] = m_acc;
      11: m_acc = p < 3 ? in_data[p*4 +: 4] : 4'd0;
      12: if (p < 3) begin
        m_out[p] = m_acc;
        we_t = cyc + 2;
        we_v = 3'(1 << p);
      end
      13: m_pc = f;
      14: if (m_c) m_pc = f;
      15: if (!m_z) m_pc = f;
      default: ;
    endcase
  endtask

  // Memory slave plus the single compare process
  always @(negedge clk) begin
    cyc++;
    if (!active) begin
      bus.ack = 0;
      prev_req = 0;
      prev_ack = 0;
      wcnt = new_wait();
      we_t = -1;
      nfetch = 0;
      m_pc = '0;
      m_acc = '0;
      m_c = 0;
      m_z = 0;
      for (int k = 0; k < 3; k++) m_out[k] = '0;
    end else begin
      if (bus.req) begin
        bus.ack = wcnt == 0;
        if (wcnt > 0) wcnt--;
      end else bus.ack = $urandom_range(0, 3) == 0;
      chk("out_we", 32'(out_we), cyc == we_t ? 32'(we_v) : 32'd0);
      if (prev_req && !prev_ack) begin
        chk("req_hold", 32'(bus.req), 32'd1);
        chk("addr_hold", 32'(bus.addr), 32'(prev_addr));
      end
      if (bus.req) begin
        chk("pc", 32'(pc), 32'(m_pc));
        chk("imem_addr", 32'(bus.addr), 32'(m_pc));
        chk("acc", 32'(acc), 32'(m_acc));
        chk("flag_c", 32'(flag_c), 32'(m_c));
        chk("flag_z", 32'(flag_z), 32'(m_z));
        chk("out_data", 32'(out_data), 32'({m_out[2], m_out[1], m_out[0]}));
      end
      if (bus.req && bus.ack) begin
        in_data = 12'($urandom);
        exec_ins(prog[bus.addr]);
        nfetch++;
        wcnt = new_wait();
      end
      prev_req = bus.req;
      prev_ack = bus.ack;
      prev_addr = bus.addr;
    end
  end

  task automatic wait_fetch(input int k);
    int t = 0;
    while (nfetch < k && t < 3000) begin
      @(posedge clk);
      #2;
      t++;
    end
    if (nfetch < k) begin
      checks++;
      errors++;
      $display("FAIL wait_fetch: got %0d fetches expected %0d", nfetch, k);
    end
  endtask

  task automatic do_reset();
    active = 0;
    rst_n = 0;
    @(posedge clk);
    #2;
    chk("rst_req", 32'(bus.req), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_acc", 32'(acc), 32'd0);
    chk("rst_flags", 32'({flag_c, flag_z}), 32'd0);
    chk("rst_out", 32'(out_data), 32'd0);
    chk("rst_we", 32'(out_we), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1;
    active = 1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 4096; i++) prog[i] = '0;
  endtask

  task automatic random_prog();
    logic [3:0] op;
    for (int i = 0; i < 4096; i++) begin
      op = 4'($urandom_range(0, 15));
      prog[i] = {op, (op inside {4'h8, 4'h9, 4'hA}) ? 12'($urandom & 32'hF07) : 12'($urandom)};
    end
    for (int k = 0; k < 8; k++) begin
      prog[2*k] = {8'h10, 4'($urandom)};
      prog[2*k+1] = {4'h9, 12'(k)};
    end
  endtask

  initial begin
    run = 1;
    for (int n = 0; n < 2; n++) begin
      wmax = n == 0 ? 0 : 5;
      clear_prog();
      prog[0] = 16'h1009;
      prog[1] = 16'h2008;
      prog[2] = 16'h3001;
      do_reset();
      wait_fetch(2);
      chk("t2_add_acc", 32'(m_acc), 32'd1);
      chk("t2_add_flags", 32'({m_c, m_z}), 32'b10);
      wait_fetch(3);
      chk("t2_sub_acc", 32'(m_acc), 32'd0);
      chk("t2_sub_flags", 32'({m_c, m_z}), 32'b01);
      wait_fetch(5);
    end
    wmax = -1;
    clear_prog();
    prog[0] = 16'h1005;
    prog[1] = 16'h9010;
    prog[2] = 16'h1000;
    prog[3] = 16'hA010;
    prog[4] = 16'hC001;
    do_reset();
    wait_fetch(5);
    chk("t4_out1", 32'(m_out[1]), 32'd5);
    chk("t4_we", 32'(we_v), 32'b010);
    chk("t4_acc", 32'(m_acc), 32'd5);
    wait_fetch(7);
    clear_prog();
    prog[0] = 16'h1002;
    prog[1] = 16'h7003;
    prog[2] = 16'hE040;
    prog[12'h040] = 16'h7002;
    prog[12'h041] = 16'hF100;
    do_reset();
    wait_fetch(2);
    chk("t5_cmp_flags", 32'({m_c, m_z}), 32'b10);
    wait_fetch(3);
    chk("t5_jc_pc", 32'(m_pc), 32'h040);
    wait_fetch(5);
    chk("t5_jnz_pc", 32'(m_pc), 32'h042);
    chk("t5_z", 32'(m_z), 32'd1);
    wait_fetch(7);
    clear_prog();
    prog[0] = 16'h100F;
    prog[1] = 16'h2001;
    prog[2] = 16'h1006;
    prog[3] = 16'hDFFE;
    prog[12'hFFE] = 16'hB007;
    do_reset();
    wait_fetch(5);
    chk("t6_in_acc", 32'(m_acc), 32'd0);
    chk("t6_flags", 32'({m_c, m_z}), 32'b11);
    chk("t6_pc", 32'(m_pc), 32'hFFF);
    wait_fetch(6);
    chk("t6_wrap", 32'(m_pc), 32'h000);
    wait_fetch(8);
    random_prog();
    do_reset();
    wait_fetch(400);
    run = 0;
    repeat (14) @(posedge clk);
    #2;
    chk("idle_req", 32'(bus.req), 32'd0);
    chk("idle_pc", 32'(pc), 32'(m_pc));
    chk("idle_acc", 32'(acc), 32'(m_acc));
    repeat (3) @(posedge clk);
    #2;
    chk("idle_req_hold", 32'(bus.req), 32'd0);
    run = 1;
    wmax = 5;
    wait_fetch(nfetch + 2);
    for (int t = 0; t < 20 && !bus.req; t++) begin
      @(posedge clk);
      #2;
    end
    chk("midfetch_req", 32'(bus.req), 32'd1);
    do_reset();
    wmax = -1;
    wait_fetch(300);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
